fifo_reader: RTL

Read-side controller for the data FIFO. It drains the FIFO by issuing single-cycle read strobes, captures the registered read data one cycle later, and presents it downstream on a valid/ready interface through a 2-entry output buffer. It never reads an empty FIFO, tolerates downstream backpressure without losing data, and halts on a FIFO error until software clears it.

---
 rtl/fifo_reader_pkg.sv | 15 +
 rtl/fifo_reader_outbuf.sv | 53 +++++
 rtl/fifo_reader.sv | 104 ++++++++++
 3 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the fifo_reader read-side controller.
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_SIZE = 4;
    localparam int DEFAULT_CNT_SIZE  = 16;
    localparam int OUTBUF_DEPTH      = 2;
    localparam int OCC_W             = $clog2(OUTBUF_DEPTH + 1);

endpackage

// File: rtl/fifo_reader_outbuf.sv
// Two-entry output buffer: push at the tail, pop from the head, occupancy count.
// Pure storage; all flow-control decisions live in fifo_reader.
module fifo_reader_outbuf
    import fifo_reader_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic [OCC_W-1:0]     occ,
    output logic [DATA_SIZE-1:0] head
);

    logic [DATA_SIZE-1:0] mem [OUTBUF_DEPTH];
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic                 do_pop;

    assign do_pop = pop && (occ != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the entries are reset too, because the head drives out_data and must read zero after reset.
            for (int i = 0; i < OUTBUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= '0;
        end else begin
            assert (!(push && occ == OCC_W'(OUTBUF_DEPTH)));
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !do_pop) begin
                occ <= occ + OCC_W'(1);
            end else if (!push && do_pop) begin
                occ <= occ - OCC_W'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_reader.sv
// Read-side FIFO controller: credit-limited read strobes, 2-entry output buffer, HALT on FIFO error.
// Define FIFO_READER_COUNT_EN to add the rd_count delivered-word counter.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE
`ifdef FIFO_READER_COUNT_EN
    , parameter int CNT_SIZE = DEFAULT_CNT_SIZE
`endif
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [DATA_SIZE-1:0] fifo_data,
    input  logic                 fifo_error,
    output logic                 fifo_read,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 halted,
    input  logic                 clear_err
`ifdef FIFO_READER_COUNT_EN
    , output logic [CNT_SIZE-1:0] rd_count
`endif
);

    state_t           state;
    state_t           state_next;
    logic             inflight;
    logic             pop;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   credits_used;

    assign pop = out_valid && out_ready;

    // A word leaving this cycle frees its slot for a read issued now, which is
    // what allows one word per cycle while out_ready stays high.
    assign credits_used = {1'b0, occ} + (OCC_W+1)'(inflight) - (OCC_W+1)'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first, so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            ST_IDLE: if (enable && !fifo_empty)  state_next = ST_RUN;
            ST_RUN:  if (!enable || fifo_empty)  state_next = ST_IDLE;
            ST_HALT: if (clear_err)              state_next = ST_IDLE;
            default:                             state_next = ST_IDLE;
        endcase
        if (state != ST_HALT && fifo_read && fifo_error) begin
            state_next = ST_HALT;
        end
    end

    always_comb begin
        fifo_read = (state == ST_RUN) && enable && !fifo_empty &&
                    (credits_used < (OCC_W+1)'(OUTBUF_DEPTH));
        halted    = (state == ST_HALT);
    end

    // The read word is captured even if the FSM has just left RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_read;
        end
    end

    fifo_reader_outbuf #(
        .DATA_SIZE (DATA_SIZE)
    ) u_outbuf (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (pop),
        .occ       (occ),
        .head      (out_data)
    );

    assign out_valid = (occ != '0);

`ifdef FIFO_READER_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + CNT_SIZE'(1);
        end
    end
`endif

endmodule
